// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg : shared fetch types, FSM encoding and defaults  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_queue_pkg;

  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetch_entry_t;

  // Word-granular addressing; the 32-bit add wraps FFFF_FFFF to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if : memory-read and instruction-delivery bundle      | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_addr;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_addr,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_addr
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_addr,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_addr
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : DEPTH x 64-bit in-order entry storage with flush     | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  wire  logic                     clock,
  input  wire  logic                     reset,
  input  wire  logic                     push,
  input  wire  logic                     pop,
  input  wire  logic                     flush,
  input  wire  fetch_entry_t             wr_data,
  output       fetch_entry_t             rd_data,
  output       logic [$clog2(DEPTH):0]   count,
  output       logic                     full,
  output       logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue : single-outstanding instruction prefetcher with flush | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic      clock,
  input  wire logic      reset,
  fetch_queue_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [31:0]         pc;
  logic [31:0]         pc_next;
  logic [31:0]         req_addr;
  logic [31:0]         req_addr_next;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  fetch_entry_t        head;
  fetch_entry_t        new_entry;

  assign new_entry = '{word: bus.mem_rdata, addr: req_addr};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push && !full),
    .pop     (pop),
    .flush   (bus.redirect),
    .wr_data (new_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    push          = 1'b0;
    pop           = bus.instr_valid && bus.instr_ready && !bus.redirect;

    unique case (state)
      ST_IDLE: begin
        // A redirect empties the queue, so it may issue straight to the new target.
        if (bus.redirect) begin
          state_next    = ST_REQ;
          req_addr_next = bus.redirect_addr;
        end else if (count < CNT_W'(DEPTH)) begin
          state_next    = ST_REQ;
          req_addr_next = pc;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          state_next = ST_IDLE;
          if (!bus.redirect) begin
            push    = 1'b1;
            pc_next = next_pc(req_addr);
          end
        end else if (bus.redirect) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.mem_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.redirect) pc_next = bus.redirect_addr;
  end

  assign bus.mem_req     = (state != ST_IDLE);
  assign bus.mem_addr    = req_addr;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? 32'h0 : head.word;
  assign bus.instr_addr  = empty ? 32'h0 : head.addr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue : randomized bench with transaction-level queue model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0010;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        mq[$];
  logic        outstanding;
  logic        dropped;
  logic [31:0] out_addr;
  logic [31:0] exp_pc;
  int          wait_left;
  int          idle_cnt;
  int          ready_pct;
  int          redir_pct;
  int          max_wait;
  logic        pend_redir  = 1'b0;
  logic [31:0] pend_addr   = '0;
  logic        did_reset   = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    outstanding = 1'b0;
    dropped     = 1'b0;
    exp_pc      = RESET_PC;
    idle_cnt    = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, "_req"},   32'(bus.mem_req),     32'h0);
    check_value({tag, "_addr"},  bus.mem_addr,         32'h0);
    check_value({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    check_value({tag, "_instr"}, bus.instr,            32'h0);
    check_value({tag, "_iaddr"}, bus.instr_addr,       32'h0);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    check_value("pre_reset_req", 32'(bus.mem_req), 32'h1);
    reset            = 1'b1;
    bus.mem_ack      = 1'b0;
    bus.redirect     = 1'b0;
    bus.instr_ready  = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: observe at negedge, drive next inputs, advance the model past the coming posedge.
  task automatic step();
    logic [31:0] ra;
    logic        rdy;
    logic        rdr;
    @(negedge clock);

    check_value("instr_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_value("instr",      bus.instr,      mq[0].word);
      check_value("instr_addr", bus.instr_addr, mq[0].addr);
    end else begin
      check_value("instr_empty",      bus.instr,      32'h0);
      check_value("instr_addr_empty", bus.instr_addr, 32'h0);
    end

    if (bus.mem_req && !outstanding) begin
      check_value("req_addr",  bus.mem_addr, exp_pc);
      check_value("req_space", 32'(mq.size() < DEPTH), 32'h1);
      outstanding = 1'b1;
      dropped     = 1'b0;
      out_addr    = bus.mem_addr;
      wait_left   = $urandom_range(0, max_wait);
    end else if (outstanding) begin
      check_value("req_hold",  32'(bus.mem_req), 32'h1);
      check_value("addr_hold", bus.mem_addr,     out_addr);
    end

    if (!bus.mem_req && mq.size() < DEPTH) idle_cnt++;
    else idle_cnt = 0;
    check_value("idle_stall", 32'(idle_cnt > 1), 32'h0);

    rdy = ($urandom_range(0, 99) < ready_pct);
    rdr = ($urandom_range(0, 99) < redir_pct);
    case ($urandom_range(0, 3))
      0:       ra = 32'hFFFF_FFFF;
      1:       ra = 32'h0000_0100;
      2:       ra = 32'h0000_0200;
      default: ra = $urandom;
    endcase
    if (pend_redir) begin
      rdr        = 1'b1;
      ra         = pend_addr;
      pend_redir = 1'b0;
    end
    bus.instr_ready   = rdy;
    bus.redirect      = rdr;
    bus.redirect_addr = ra;
    bus.mem_rdata     = $urandom;
    if (outstanding) begin
      bus.mem_ack = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      bus.mem_ack = ($urandom_range(0, 19) == 0);
    end

    if (mq.size() > 0 && rdy && !rdr) void'(mq.pop_front());
    if (outstanding && bus.mem_ack) begin
      if (!dropped && !rdr) begin
        mq.push_back('{word: bus.mem_rdata, addr: out_addr});
        exp_pc = out_addr + 32'd1;
      end
      outstanding = 1'b0;
    end else if (outstanding && rdr) begin
      dropped = 1'b1;
    end
    if (rdr) begin
      mq.delete();
      exp_pc = ra;
    end
  endtask

  task automatic run(input int n, input int rp, input int dp, input int mw);
    ready_pct = rp;
    redir_pct = dp;
    max_wait  = mw;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run(20, 100, 0, 0);

    run(30, 0, 0, 1);
    check_value("fill_count", 32'(mq.size()), 32'(DEPTH));
    check_value("full_no_req", 32'(bus.mem_req), 32'h0);
    run(20, 100, 0, 0);

    pend_redir = 1'b1;
    pend_addr  = 32'hFFFF_FFFF;
    run(12, 100, 0, 0);

    run(10, 50, 0, 3);
    pend_redir = 1'b1;
    pend_addr  = 32'h0000_0100;
    run(10, 50, 0, 3);

    ready_pct = 60;
    redir_pct = 8;
    max_wait  = 3;
    for (int i = 0; i < 3000; i++) begin
      if (!did_reset && i > 1500 && outstanding && !bus.mem_ack) begin
        did_reset = 1'b1;
        async_reset();
      end
      step();
    end
    check_value("reset_taken", 32'(did_reset), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction word entries buffered (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first word address fetched after reset.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  memory read request, held until acknowledged.
REQ-006 mem_addr  output  32  word address of the current request, stable while mem_req=1.
REQ-007 mem_ack  input  1  memory read completion; mem_rdata valid in the same cycle.
REQ-008 mem_rdata  input  32  instruction word returned by memory.
REQ-009 instr_valid  output  1  head entry holds a valid instruction.
REQ-010 instr  output  32  head instruction word; 0 when the queue is empty.
REQ-011 instr_addr  output  32  word address of the head instruction; 0 when the queue is empty.
REQ-012 instr_ready  input  1  CPU consumes the head entry when instr_valid=1.
REQ-013 redirect  input  1  one-cycle branch/jump pulse: flush and restart fetch.
REQ-014 redirect_addr  input  32  new fetch word address, sampled when redirect=1.

Function
REQ-015 Addressing is word-granular: after each accepted word, fetch pc increments by 1, with wrap 32'hFFFF_FFFF -> 0.
REQ-016 The FSM has three states: IDLE (no request outstanding), REQ (request outstanding), DROP (outstanding request whose data shall be discarded).
REQ-017 IDLE -> REQ when count < DEPTH and redirect=0; mem_req=1 and mem_addr=pc from the next cycle.
REQ-018 In REQ, mem_req stays 1 and mem_addr stays unchanged until mem_ack=1; at most one request is outstanding at any time.
REQ-019 REQ with mem_ack=1 and redirect=0: {mem_rdata, mem_addr} is pushed, pc increments, and the next state is IDLE; back-to-back requests therefore issue every 2 cycles.
REQ-020 REQ with redirect=1 and mem_ack=0 -> DROP; in DROP, mem_req stays 1 until mem_ack; on mem_ack the data is discarded and the next state is IDLE.
REQ-021 REQ with redirect=1 and mem_ack=1 in the same cycle: the data is discarded and the next state is IDLE.
REQ-022 Any redirect empties the queue (count=0, instr_valid=0 next cycle) and loads pc=redirect_addr; a pop in the same cycle is ignored.
REQ-023 After a redirect in cycle N with no request outstanding, mem_req with mem_addr=redirect_addr is asserted in cycle N+1.
REQ-024 Pop occurs when instr_valid=1, instr_ready=1 and redirect=0; the head advances in the following cycle.
REQ-025 A push and a pop in the same cycle leave count unchanged; a push into a full queue cannot occur because no request is issued while count=DEPTH.
REQ-026 Entries are delivered in order; instr and instr_addr are driven from registered storage (no combinational path from mem_rdata).
REQ-027 A redirect received during DROP updates pc again; the last redirect wins.

Reset
REQ-028 Reset asserted: state=IDLE, pc=RESET_PC, count=0, read and write pointers=0; mem_req, mem_addr, instr_valid, instr and instr_addr are all 0.
REQ-029 Reset asserted mid-transaction abandons the request; an acknowledge arriving after reset is ignored unless the block is in REQ or DROP.
REQ-030 The first mem_req after reset deassertion is asserted in the second clock edge's cycle, with mem_addr=RESET_PC.

Structure
REQ-031 The state encoding (IDLE=0, REQ=1, DROP=2), the DEPTH default and the RESET_PC default belong in the shared CPU package.
REQ-032 The storage is one sub-module, fetch_fifo (DEPTH x 64-bit, with push, pop, flush, count, full and empty), instantiated once.

Verification
REQ-033 Reset, 0-wait memory, instr_ready=1 -> mem_addr sequence 0,1,2,3; instr/instr_addr pairs delivered in order with matching values.
REQ-034 instr_ready=0, memory returns 0xA0..0xA5 -> exactly 4 words queued, mem_req stays 0 while full; then set ready=1 -> 0xA0..0xA3 delivered, fetch resumes at address 4.
REQ-035 Redirect to 0x100 while REQ is waiting 3 cycles for ack -> the stale word is not queued; the next mem_addr is 0x100.
REQ-036 Redirect to 0x200 coincident with mem_ack and with a pop -> queue empty next cycle, data dropped, next mem_addr is 0x200.
REQ-037 redirect_addr=32'hFFFF_FFFF -> fetches FFFF_FFFF then 0000_0000.
REQ-038 Reset asserted while mem_req=1 at address 5 -> outputs are 0 immediately (asynchronously); after release, mem_addr=RESET_PC.
